// File: rtl/rbm_ctrl_pkg.sv
// Shared types and constants for the contrastive-divergence batch controller.
package rbm_ctrl_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_TO_W  = 12;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        PRIME,
        STREAM,
        WAIT,
        ABORT_WAIT,
        UPD
    } state_e;

    localparam logic POS = 1'b0;
    localparam logic NEG = 1'b1;

endpackage

// File: rtl/cd_watchdog.sv
// Free-running wait-state watchdog: held at zero while clr is high, counts up otherwise.
module cd_watchdog
    import rbm_ctrl_pkg::*;
#(
    parameter int TO_W = DEF_TO_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    assign cnt_d = clr ? '0 : cnt_q + TO_W'(1);

    // Expires on the limit-th waiting cycle; a zero limit behaves like one.
    assign expired = ({1'b0, cnt_q} + (TO_W+1)'(1)) >= {1'b0, limit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cd_phase_sequencer.sv
// Drives one CD batch through the outer-product accumulator: clear, positive phase,
// negative phase, then a level handshake with the weight-update engine.
module cd_phase_sequencer
    import rbm_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int TO_W  = DEF_TO_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_batch,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             abort,
    input  logic             src_valid,
    output logic             src_ready,
    output logic             src_neg,
    output logic             acc_clr_pos,
    output logic             acc_clr_neg,
    output logic             acc_neg_phase,
    output logic             acc_sample_valid,
    output logic             acc_last_sample,
    output logic             acc_gate,
    input  logic             acc_done,
    output logic             upd_req,
    input  logic             upd_ack,
    output logic             busy,
    output logic             batch_done,
    output logic             err
);

    state_e           state_q;
    logic             phase_q;
    logic [CNT_W-1:0] batch_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TO_W-1:0]  timeout_q;
    logic             clr_q;
    logic             sv_q;
    logic             force_last_q;
    logic             upd_req_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             beat;
    logic             last_beat;
    logic             in_wait;
    logic             wd_clr;
    logic             wd_expired;

    // The source handshake and its gate/last qualifiers share one cycle so the
    // datapath zeroes v_i exactly on bubble cycles.
    assign src_ready = (state_q == STREAM) && (cnt_q < batch_q);
    assign beat      = src_valid && src_ready;
    assign last_beat = beat && (cnt_q == batch_q - CNT_W'(1));

    assign in_wait = (state_q == WAIT) || (state_q == ABORT_WAIT);
    assign wd_clr  = !in_wait || ((state_q == WAIT) && abort);

    cd_watchdog #(
        .TO_W (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .limit   (timeout_q),
        .expired (wd_expired)
    );

    assign acc_gate         = beat;
    assign acc_last_sample  = last_beat || force_last_q;
    assign acc_clr_pos      = clr_q;
    assign acc_clr_neg      = clr_q;
    assign acc_neg_phase    = phase_q;
    assign src_neg          = phase_q;
    assign acc_sample_valid = sv_q;
    assign upd_req          = upd_req_q;
    assign busy             = busy_q;
    assign batch_done       = done_q;
    assign err              = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= POS;
            batch_q      <= '0;
            cnt_q        <= '0;
            timeout_q    <= '0;
            clr_q        <= 1'b0;
            sv_q         <= 1'b0;
            force_last_q <= 1'b0;
            upd_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            clr_q        <= 1'b0;
            sv_q         <= 1'b0;
            force_last_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_batch == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            batch_q   <= cfg_batch;
                            timeout_q <= cfg_timeout;
                            phase_q   <= POS;
                            cnt_q     <= '0;
                            clr_q     <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= CLR;
                        end
                    end
                end
                CLR: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        sv_q    <= 1'b1;
                        state_q <= PRIME;
                    end
                end
                PRIME: begin
                    if (abort) begin
                        phase_q <= POS;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    // A completing beat wins over abort; abort is then seen again in WAIT.
                    if (last_beat) begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end else if (abort) begin
                        cnt_q        <= '0;
                        force_last_q <= 1'b1;
                        state_q      <= ABORT_WAIT;
                    end else if (beat) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (acc_done) begin
                        if (abort) begin
                            phase_q <= POS;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end else if (phase_q == POS) begin
                            phase_q <= NEG;
                            sv_q    <= 1'b1;
                            state_q <= PRIME;
                        end else begin
                            upd_req_q <= 1'b1;
                            state_q   <= UPD;
                        end
                    end else if (wd_expired) begin
                        phase_q <= POS;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (abort) begin
                        state_q <= ABORT_WAIT;
                    end
                end
                ABORT_WAIT: begin
                    if (acc_done || wd_expired) begin
                        phase_q <= POS;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                UPD: begin
                    if (upd_ack) begin
                        upd_req_q <= 1'b0;
                        phase_q   <= POS;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end else if (abort) begin
                        upd_req_q <= 1'b0;
                        phase_q   <= POS;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
